norm_shift32: RTL and testbench
===============================

// Module: norm_shift32
// PURPOSE
//  Multi-cycle normalizer for the ALU datapath: inverse of the shift operation.
//  Given a word, it finds the shift amount that brings the first set bit to the
//  MSB (left) or the LSB (right), and returns the normalized word plus that amount.
//  It uses a log2-stage binary search, one stage per clock (16,8,4,2,1), with a
//  START/BUSY/DONE handshake toward the control unit.
// PARAMETERS
//  DATA_WIDTH  32  operand width; power of two, >=4
//  CNT_WIDTH   6   count width = log2(DATA_WIDTH)+1 (holds DATA_WIDTH for zero input)
// PORTS
//  CLK    in   1           clock, rising edge
//  RST    in   1           asynchronous, active-low reset
//  START  in   1           request; sampled only in IDLE
//  D      in   DATA_WIDTH  operand, captured with START
//  LnR    in   1           1 = normalize toward MSB (count leading zeros), 0 = toward LSB (trailing)
//  Y      out  DATA_WIDTH  normalized word
//  CNT    out  CNT_WIDTH   shift amount applied
//  ZERO   out  1           operand was all zero
//  BUSY   out  1           operation in progress
//  DONE   out  1           one-cycle pulse: Y/CNT/ZERO valid
// BEHAVIOUR
//  - Reset (RST=0, async): state IDLE; Y=0, CNT=0, ZERO=0, BUSY=0, DONE=0; work regs cleared.
//  - States: IDLE -> SCAN -> FIN -> IDLE.
//  - IDLE: when START=1 at edge E0, latch D into W, latch LnR, clear acc count, set stage=4, BUSY=1.
//    If D==0, go to FIN directly (no SCAN).
//  - SCAN: on each edge, for stage k (shift n=2^k, k=4..0):
//    - Left: if W[DW-1 -: n]==0, then W<=W<<n and count+=n.
//    - Right: if W[n-1:0]==0, then W<=W>>n and count+=n.
//    - After k=0, go to FIN. Fill bits are 0.
//  - FIN (one edge): Y<=W, CNT<=count, ZERO<=(W==0), DONE<=1, BUSY<=0, then go to IDLE.
//    For zero input: Y=0, CNT=DATA_WIDTH, ZERO=1.
//  - Latency (default, nonzero D): DONE is high in the cycle after edge E0+6; BUSY is high for
//    cycles E0+1..E0+6. For zero D: DONE is high after edge E0+2.
//  - DONE is high for exactly 1 cycle.
//  - Y/CNT/ZERO hold their values until the next FIN. They are unchanged while BUSY.
//  - START while BUSY/FIN is ignored (not queued).
//  - START in the same cycle DONE is high is accepted: the FSM is already in IDLE.
//  - LnR/D changes after E0 have no effect on the operation in progress.
//  - Reset mid-operation aborts immediately to the reset values. No DONE is issued.
//  - Invariant: left mode gives Y[DW-1]=1 and Y==D<<CNT; right mode gives Y[0]=1 and Y==D>>CNT
//    (both for nonzero D).
// CONFIGURATION
//  NORM_EARLY_EXIT_EN
//  - Defined: in SCAN, if the target edge bit (W[DW-1] for left, W[0] for right) is already 1
//    before a stage is applied, go to FIN on that edge without shifting. Latency is variable
//    (2..6 edges after E0). Results are identical.
//  - Undefined: all log2(DATA_WIDTH) SCAN stages always run, giving fixed latency.
// TESTING
//  1. D=0x00010000, LnR=1 -> Y=0x80000000, CNT=15, ZERO=0, DONE at E0+6 (fixed latency).
//  2. D=0x00010000, LnR=0 -> Y=0x00000001, CNT=16, ZERO=0.
//  3. D=0x00000000, either LnR -> Y=0, CNT=32, ZERO=1, DONE at E0+2.
//  4. D=0x80000000, LnR=1 -> Y=0x80000000, CNT=0.
//     With NORM_EARLY_EXIT_EN: DONE at E0+2. Without it: DONE at E0+6.
//  5. START pulses at E0+2 and E0+4 with a different D -> ignored; result matches the first D.
//     START in the DONE cycle -> the second result follows normally.
//  6. RST low at E0+3 -> all outputs 0 immediately, no DONE.
//     After release: D=0x00000003, LnR=1 -> CNT=30, Y=0xC0000000.

Source files
------------

// File: rtl/norm_shift32.sv
// Multi-cycle normalizer: finds the shift that brings the first set bit to the MSB (LnR=1) or LSB (LnR=0).
// Binary search one stage per clock (DW/2 .. 1); define NORM_EARLY_EXIT_EN to finish as soon as the edge bit is set.
module norm_shift32 #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  START,
   input  logic [DATA_WIDTH-1:0] D,
   input  logic                  LnR,
   output logic [DATA_WIDTH-1:0] Y,
   output logic [CNT_WIDTH-1:0]  CNT,
   output logic                  ZERO,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [1:0]            dbg_state_o
);

   // Handshake: START is sampled only in IDLE; BUSY covers the whole operation; DONE is a
   // one-cycle pulse and Y/CNT/ZERO stay valid until the next completion.

   localparam int STAGE_W = $clog2(CNT_WIDTH);
   localparam logic [STAGE_W-1:0]   STAGE_INIT = STAGE_W'($clog2(DATA_WIDTH) - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = CNT_WIDTH'(DATA_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   state_t                  state_q;
   logic [DATA_WIDTH-1:0]   w_q;
   logic [DATA_WIDTH-1:0]   w_d;
   logic [CNT_WIDTH-1:0]    cnt_q;
   logic [CNT_WIDTH-1:0]    cnt_d;
   logic [STAGE_W-1:0]      stage_q;
   logic                    lnr_q;
   logic                    fin_arm_q;
   logic [DATA_WIDTH-1:0]   y_q;
   logic [CNT_WIDTH-1:0]    cnt_out_q;
   logic                    zero_q;
   logic                    busy_q;
   logic                    done_q;

   logic [CNT_WIDTH-1:0]    shamt;
   logic [DATA_WIDTH-1:0]   left_mask;
   logic [DATA_WIDTH-1:0]   right_mask;
   logic                    take_shift;
   logic                    early_exit;

   always_comb begin
      shamt      = CNT_WIDTH'(1) << stage_q;
      left_mask  = ~({DATA_WIDTH{1'b1}} >> shamt);
      right_mask = ~({DATA_WIDTH{1'b1}} << shamt);
      take_shift = lnr_q ? ((w_q & left_mask) == '0) : ((w_q & right_mask) == '0);
      w_d        = w_q;
      cnt_d      = cnt_q;
      if (take_shift) begin
         w_d   = lnr_q ? (w_q << shamt) : (w_q >> shamt);
         cnt_d = cnt_q + shamt;
      end
   end

`ifdef NORM_EARLY_EXIT_EN
   assign early_exit = lnr_q ? w_q[DATA_WIDTH-1] : w_q[0];
`else
   assign early_exit = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= ST_IDLE;
         w_q       <= '0;
         cnt_q     <= '0;
         stage_q   <= '0;
         lnr_q     <= 1'b0;
         fin_arm_q <= 1'b0;
         y_q       <= '0;
         cnt_out_q <= '0;
         zero_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (START) begin
                  w_q     <= D;
                  lnr_q   <= LnR;
                  stage_q <= STAGE_INIT;
                  busy_q  <= 1'b1;
                  if (D == '0) begin
                     // A zero operand skips the search but waits one extra cycle in FIN.
                     cnt_q     <= CNT_ZERO;
                     fin_arm_q <= 1'b0;
                     state_q   <= ST_FIN;
                  end else begin
                     cnt_q     <= '0;
                     fin_arm_q <= 1'b1;
                     state_q   <= ST_SCAN;
                  end
               end
            end
            ST_SCAN: begin
               if (early_exit) begin
                  state_q <= ST_FIN;
               end else begin
                  w_q   <= w_d;
                  cnt_q <= cnt_d;
                  if (stage_q == '0) begin
                     state_q <= ST_FIN;
                  end else begin
                     stage_q <= stage_q - 1'b1;
                  end
               end
            end
            ST_FIN: begin
               if (!fin_arm_q) begin
                  fin_arm_q <= 1'b1;
               end else begin
                  y_q       <= w_q;
                  cnt_out_q <= cnt_q;
                  zero_q    <= (w_q == '0);
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign Y           = y_q;
   assign CNT         = cnt_out_q;
   assign ZERO        = zero_q;
   assign BUSY        = busy_q;
   assign DONE        = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_norm_shift32.sv
// Self-checking bench for norm_shift32: vector table, random operands and handshake/reset sequences.
// Latency expectations follow NORM_EARLY_EXIT_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_norm_shift32;

   localparam int DW = 32;
   localparam int CW = 6;
   localparam int RW = DW + CW + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] d = '0;
   logic          lnr = 1'b0;
   logic [DW-1:0] y;
   logic [CW-1:0] cnt;
   logic          zero;
   logic          busy;
   logic          done;
   logic [1:0]    dbg_state;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   norm_shift32 dut (
      .CLK         (clk),
      .RST         (rst_n),
      .START       (start),
      .D           (d),
      .LnR         (lnr),
      .Y           (y),
      .CNT         (cnt),
      .ZERO        (zero),
      .BUSY        (busy),
      .DONE        (done),
      .dbg_state_o (dbg_state)
   );

   int            n_checks = 0;
   int            n_fail = 0;
   logic [RW-1:0] exp_q[$];
   logic          done_prev = 1'b0;
   logic [DW-1:0] y_hold;

   typedef struct {
      logic [DW-1:0] d;
      logic          lnr;
      logic [DW-1:0] y;
      logic [CW-1:0] cnt;
      logic          zero;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: walk bit by bit toward the target edge.
   function automatic logic [RW-1:0] model(input logic [DW-1:0] dv, input logic lv);
      logic [DW-1:0] w;
      int            c;
      if (dv == '0) return {{DW{1'b0}}, CW'(DW), 1'b1};
      w = dv;
      c = 0;
      if (lv) begin
         while (!w[DW-1]) begin w = w << 1; c++; end
      end else begin
         while (!w[0]) begin w = w >> 1; c++; end
      end
      return {w, CW'(c), 1'b0};
   endfunction

   function automatic int exp_lat(input logic [DW-1:0] dv, input logic lv);
      if (dv == '0) return 2;
`ifdef NORM_EARLY_EXIT_EN
      begin
         logic [DW-1:0] w;
         w = dv;
         for (int k = 4; k >= 0; k--) begin
            int n;
            if (lv ? w[DW-1] : w[0]) return (4 - k) + 2;
            n = 1 << k;
            if (lv) begin
               if ((w >> (DW - n)) == '0) w = w << n;
            end else begin
               if ((w << (DW - n)) == '0) w = w >> n;
            end
         end
      end
`endif
      return 6;
   endfunction

   // ---------------- driver tasks ----------------
   // Called #1 after a rising edge; returns #1 after the accepting edge E0.
   task automatic start_op(input logic [DW-1:0] dv, input logic lv, input logic [RW-1:0] e,
                           input bit push);
      if (push) exp_q.push_back(e);
      start = 1'b1;
      d     = dv;
      lnr   = lv;
      @(posedge clk); #1;
      start  = 1'b0;
      d      = $urandom;
      lnr    = 1'($urandom_range(0, 1));
      y_hold = y;
      check("busy_after_start", {63'd0, busy}, 64'd1);
   endtask

   // Counts edges after E0 until DONE; optional ignored START pokes at edges E0+poke_a/poke_b.
   task automatic wait_done(input int lat_exp, input string name, input int poke_a, input int poke_b);
      int lat;
      bit held;
      lat  = 0;
      held = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         if (i == poke_a || i == poke_b) begin
            start = 1'b1;
            d     = 32'hFFFF_0000;
            lnr   = 1'b0;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         if (done) begin
            lat = i;
            break;
         end
         if (y !== y_hold) held = 1'b0;
      end
      start = 1'b0;
      check({name, "_latency"}, 64'(lat), 64'(lat_exp));
      check({name, "_y_hold"}, {63'd0, held}, 64'd1);
      check({name, "_busy_clear"}, {63'd0, busy}, 64'd0);
   endtask

   // ---------------- scoreboard ----------------
   always @(posedge clk) begin
      #1;
      if (done) begin
         check("done_pulse", {63'd0, done_prev}, 64'd0);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: Y=0x%0h CNT=%0d ZERO=%0b with no operation pending", y, cnt, zero);
         end else begin
            check("result", 64'({y, cnt, zero}), 64'(exp_q.pop_front()));
         end
      end
      done_prev = done;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- test ----------------
   initial begin
      vecs[0]  = '{32'h0001_0000, 1'b1, 32'h8000_0000, 6'd15, 1'b0};
      vecs[1]  = '{32'h0001_0000, 1'b0, 32'h0000_0001, 6'd16, 1'b0};
      vecs[2]  = '{32'h0000_0000, 1'b1, 32'h0000_0000, 6'd32, 1'b1};
      vecs[3]  = '{32'h0000_0000, 1'b0, 32'h0000_0000, 6'd32, 1'b1};
      vecs[4]  = '{32'h8000_0000, 1'b1, 32'h8000_0000, 6'd0,  1'b0};
      vecs[5]  = '{32'h0000_0001, 1'b1, 32'h8000_0000, 6'd31, 1'b0};
      vecs[6]  = '{32'h8000_0000, 1'b0, 32'h0000_0001, 6'd31, 1'b0};
      vecs[7]  = '{32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 6'd0,  1'b0};
      vecs[8]  = '{32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 6'd0,  1'b0};
      vecs[9]  = '{32'h00F0_0000, 1'b1, 32'hF000_0000, 6'd8,  1'b0};
      vecs[10] = '{32'h00F0_0000, 1'b0, 32'h0000_000F, 6'd20, 1'b0};
      vecs[11] = '{32'h0000_0003, 1'b1, 32'hC000_0000, 6'd30, 1'b0};
      vecs[12] = '{32'h0000_0001, 1'b0, 32'h0000_0001, 6'd0,  1'b0};

      repeat (3) @(posedge clk);
      #1;
      check("rst_y", 64'(y), 64'd0);
      check("rst_cnt", 64'(cnt), 64'd0);
      check("rst_zero", {63'd0, zero}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++) begin
         start_op(vecs[i].d, vecs[i].lnr, {vecs[i].y, vecs[i].cnt, vecs[i].zero}, 1'b1);
         wait_done(exp_lat(vecs[i].d, vecs[i].lnr), $sformatf("vec%0d", i), 0, 0);
      end

      // START pulses during BUSY are ignored; START in the DONE cycle is accepted.
      start_op(32'h0001_0000, 1'b1, {32'h8000_0000, 6'd15, 1'b0}, 1'b1);
      wait_done(exp_lat(32'h0001_0000, 1'b1), "ignore", 2, 4);
      start_op(32'h0000_0100, 1'b0, {32'h0000_0001, 6'd8, 1'b0}, 1'b1);
      wait_done(exp_lat(32'h0000_0100, 1'b0), "done_cycle_start", 0, 0);

      // Reset mid-operation aborts without DONE.
      start_op(32'h0001_0000, 1'b1, '0, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check("abort_y", 64'(y), 64'd0);
      check("abort_cnt", 64'(cnt), 64'd0);
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_done", {63'd0, done}, 64'd0);
      check("abort_state", 64'(dbg_state), 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("abort_no_busy", {63'd0, busy}, 64'd0);
      start_op(32'h0000_0003, 1'b1, {32'hC000_0000, 6'd30, 1'b0}, 1'b1);
      wait_done(exp_lat(32'h0000_0003, 1'b1), "after_abort", 0, 0);

      for (int i = 0; i < 24; i++) begin
         logic [DW-1:0] rd;
         logic          rl;
         rd = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 9) == 0) rd = '0;
         rl = 1'($urandom_range(0, 1));
         start_op(rd, rl, model(rd, rl), 1'b1);
         wait_done(exp_lat(rd, rl), $sformatf("rand%0d", i), 0, 0);
      end

      repeat (4) @(posedge clk);
      #2;
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
